// File: rtl/mem_port_requester_if.sv
// Bundles the host request, memory issue/response and host response signals
// of the tagged memory-port requester. The master modport is the requester's
// view; the slave modport is the view of the host and memory around it.
interface mem_port_requester_if;
  logic        host_valid;
  logic        host_ready;
  logic [11:0] host_addr;
  logic        host_wen;
  logic [15:0] host_wdata;
  logic [1:0]  mem_req_tag;
  logic [11:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wen;
  logic        mem_valid;
  logic        mem_freeze;
  logic [1:0]  mem_rsp_tag;
  logic [15:0] mem_rsp_data;
  logic        mem_rsp_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_wen;
  logic        rsp_tag_err;

  modport master (
    input  host_valid, host_addr, host_wen, host_wdata,
    input  mem_freeze, mem_rsp_tag, mem_rsp_data, mem_rsp_valid,
    input  rsp_ready,
    output host_ready, mem_req_tag, mem_addr, mem_data, mem_wen, mem_valid,
    output rsp_valid, rsp_data, rsp_wen, rsp_tag_err
  );

  modport slave (
    output host_valid, host_addr, host_wen, host_wdata,
    output mem_freeze, mem_rsp_tag, mem_rsp_data, mem_rsp_valid,
    output rsp_ready,
    input  host_ready, mem_req_tag, mem_addr, mem_data, mem_wen, mem_valid,
    input  rsp_valid, rsp_data, rsp_wen, rsp_tag_err
  );
endinterface

// File: rtl/mem_port_requester.sv
// Tagged memory-port requester: accepts host requests, issues them to memory
// with a 2-bit tag, collects out-of-order responses in a 4-entry tag table and
// returns them to the host strictly in allocation order.
//
// state | meaning
// IDLE  | no request presented to memory (mem_valid=0)
// ISSUE | registered request presented to memory until it fires (mem_valid=1)
module mem_port_requester #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_requester_if.master bus
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  alloc_ptr, head;
  logic [2:0]  outstanding;
  logic [3:0]  busy, done, wen_tab;
  logic [15:0] data_tab [4];
  logic [1:0]  req_tag_q;
  logic [11:0] addr_q;
  logic [15:0] wdata_q;
  logic        wen_q;
  logic        tag_err_q;

  logic mem_fire, accept, retire, rsp_ok, rsp_bad;

  assign mem_fire = (state_q == ISSUE) & ~bus.mem_freeze;
  // Only registered state feeds the occupancy test, so host_ready never
  // depends on a same-cycle retire.
  assign bus.host_ready = (outstanding < 3'(MAX_OUTSTANDING)) &
                          ((state_q == IDLE) | mem_fire);
  assign accept  = bus.host_valid & bus.host_ready;
  assign retire  = bus.rsp_valid & bus.rsp_ready;
  assign rsp_ok  = bus.mem_rsp_valid & busy[bus.mem_rsp_tag] & ~done[bus.mem_rsp_tag];
  assign rsp_bad = bus.mem_rsp_valid & ~(busy[bus.mem_rsp_tag] & ~done[bus.mem_rsp_tag]);

  assign bus.mem_valid   = (state_q == ISSUE);
  assign bus.mem_req_tag = bus.mem_valid ? req_tag_q : 2'd0;
  assign bus.mem_addr    = bus.mem_valid ? addr_q    : 12'd0;
  assign bus.mem_data    = bus.mem_valid ? wdata_q   : 16'd0;
  assign bus.mem_wen     = bus.mem_valid & wen_q;

  assign bus.rsp_valid   = busy[head] & done[head];
  assign bus.rsp_data    = bus.rsp_valid ? data_tab[head] : 16'd0;
  assign bus.rsp_wen     = bus.rsp_valid & wen_tab[head];
  assign bus.rsp_tag_err = tag_err_q;

  // Issue FSM next state: a fire without a new accept drops back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (mem_fire) state_d = accept ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue state and the registered request presented to memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_tag_q <= 2'd0;
      addr_q    <= 12'd0;
      wdata_q   <= 16'd0;
      wen_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_tag_q <= alloc_ptr;
        addr_q    <= bus.host_addr;
        wen_q     <= bus.host_wen;
        wdata_q   <= bus.host_wen ? bus.host_wdata : 16'd0;
      end
    end
  end

  // Allocation/retire pointers and the outstanding count.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_ptr   <= 2'd0;
      head        <= 2'd0;
      outstanding <= 3'd0;
    end else begin
      if (accept) alloc_ptr <= alloc_ptr + 2'd1;
      if (retire) head <= head + 2'd1;
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + 3'd1;
        2'b01:   outstanding <= outstanding - 3'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tag table. Retire, response capture and allocation always touch distinct
  // entries: the head is done, a capturable entry is not, and the allocation
  // slot is free.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 4'd0;
      done      <= 4'd0;
      tag_err_q <= 1'b0;
    end else begin
      if (retire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
      end
      if (rsp_ok) begin
        done[bus.mem_rsp_tag]     <= 1'b1;
        data_tab[bus.mem_rsp_tag] <= wen_tab[bus.mem_rsp_tag] ? 16'd0 : bus.mem_rsp_data;
      end
      if (rsp_bad) tag_err_q <= 1'b1;
      if (accept) begin
        busy[alloc_ptr]    <= 1'b1;
        done[alloc_ptr]    <= 1'b0;
        wen_tab[alloc_ptr] <= bus.host_wen;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_requester.sv
// Bench for mem_port_requester: directed scenarios plus a randomized phase,
// all checked each cycle against a transaction-level queue model.
module tb_mem_port_requester;
  localparam int MAX = 4;

  typedef struct {
    logic [1:0]  tag;
    logic        wen;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        done;
    logic [15:0] rdata;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_requester_if bus();
  mem_port_requester #(.MAX_OUTSTANDING(MAX)) dut (.clk(clk), .reset(reset), .bus(bus));

  int   checks = 0;
  int   errors = 0;
  int   fires  = 0;
  ent_t q[$];
  ent_t iss;
  logic issuing = 1'b0;
  int   next_tag = 0;
  logic err = 1'b0;
  int   cand[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check all outputs against the model, then advance the model.
  task automatic cycle();
    logic e_ready, e_rv, acc, ret;
    int   idx;
    ent_t e;
    #2;
    e_ready = (q.size() < MAX) && (!issuing || !bus.mem_freeze);
    e_rv    = (q.size() > 0) && q[0].done;
    chk("host_ready",  32'(bus.host_ready),  32'(e_ready));
    chk("mem_valid",   32'(bus.mem_valid),   32'(issuing));
    chk("mem_req_tag", 32'(bus.mem_req_tag), issuing ? 32'(iss.tag) : 32'd0);
    chk("mem_addr",    32'(bus.mem_addr),    issuing ? 32'(iss.addr) : 32'd0);
    chk("mem_data",    32'(bus.mem_data),    (issuing && iss.wen) ? 32'(iss.wdata) : 32'd0);
    chk("mem_wen",     32'(bus.mem_wen),     32'(issuing && iss.wen));
    chk("rsp_valid",   32'(bus.rsp_valid),   32'(e_rv));
    chk("rsp_data",    32'(bus.rsp_data),    e_rv ? 32'(q[0].rdata) : 32'd0);
    chk("rsp_wen",     32'(bus.rsp_wen),     32'(e_rv && q[0].wen));
    chk("rsp_tag_err", 32'(bus.rsp_tag_err), 32'(err));
    if (reset) begin
      q.delete();
      issuing  = 1'b0;
      next_tag = 0;
      err      = 1'b0;
    end else begin
      acc = bus.host_valid && e_ready;
      ret = e_rv && bus.rsp_ready;
      if (issuing && !bus.mem_freeze) fires++;
      if (bus.mem_rsp_valid) begin
        idx = -1;
        foreach (q[i]) if (q[i].tag == bus.mem_rsp_tag) idx = i;
        if (idx >= 0 && !q[idx].done) begin
          q[idx].done  = 1'b1;
          q[idx].rdata = q[idx].wen ? 16'd0 : bus.mem_rsp_data;
        end else begin
          err = 1'b1;
        end
      end
      if (ret) void'(q.pop_front());
      if (issuing && !bus.mem_freeze) issuing = 1'b0;
      if (acc) begin
        e.tag   = 2'(next_tag);
        e.wen   = bus.host_wen;
        e.addr  = bus.host_addr;
        e.wdata = bus.host_wdata;
        e.done  = 1'b0;
        e.rdata = 16'd0;
        q.push_back(e);
        iss      = e;
        issuing  = 1'b1;
        next_tag = (next_tag + 1) % 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic respond(input int tag, input logic [15:0] data);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = 2'(tag);
    bus.mem_rsp_data  = data;
    cycle();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic req(input logic wen);
    bus.host_valid = 1'b1;
    bus.host_wen   = wen;
    bus.host_addr  = 12'($urandom);
    bus.host_wdata = 16'($urandom);
  endtask

  initial begin
    int f0;
    int order[4];
    order = '{2, 0, 3, 1};
    bus.host_valid = 1'b0; bus.host_addr = '0; bus.host_wen = 1'b0; bus.host_wdata = '0;
    bus.mem_freeze = 1'b0; bus.mem_rsp_tag = '0; bus.mem_rsp_data = '0;
    bus.mem_rsp_valid = 1'b0; bus.rsp_ready = 1'b1;

    // Power-up reset; DUT state is unknown before it, so no model checks yet.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_host_ready", 32'(bus.host_ready),  32'd1);
    chk("rst_mem_valid",  32'(bus.mem_valid),   32'd0);
    chk("rst_rsp_valid",  32'(bus.rsp_valid),   32'd0);
    chk("rst_tag_err",    32'(bus.rsp_tag_err), 32'd0);

    // Single read at 0x123, response 0xBEEF on cycle 3.
    req(1'b0);
    bus.host_addr = 12'h123;
    cycle();
    bus.host_valid = 1'b0;
    #1;
    chk("rd_mem_valid", 32'(bus.mem_valid),   32'd1);
    chk("rd_mem_tag",   32'(bus.mem_req_tag), 32'd0);
    chk("rd_mem_addr",  32'(bus.mem_addr),    32'h123);
    cycle();
    cycle();
    respond(0, 16'hBEEF);
    #1;
    chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd_rsp_data",  32'(bus.rsp_data),  32'hBEEF);
    cycle();

    // Write held by 3 cycles of freeze; exactly one fire.
    req(1'b1);
    cycle();
    bus.host_valid = 1'b0;
    bus.mem_freeze = 1'b1;
    f0 = fires;
    repeat (3) cycle();
    bus.mem_freeze = 1'b0;
    cycle();
    cycle();
    chk("frz_fire_count", 32'(fires - f0), 32'd1);
    respond(1, 16'($urandom));
    cycle();

    // Four reads, responses out of order 2,0,3,1.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req(1'b0);
      cycle();
    end
    cycle();
    #1;
    chk("ooo_full_ready", 32'(bus.host_ready), 32'd0);
    cycle();
    bus.host_valid = 1'b0;
    for (int i = 0; i < 4; i++) respond(order[i], 16'($urandom));
    repeat (3) cycle();

    // All four done while the host stalls for 10 cycles, then drain.
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req(i[0]);
      cycle();
    end
    bus.host_valid = 1'b0;
    cycle();
    for (int i = 0; i < 4; i++) respond(i, 16'($urandom));
    bus.host_valid = 1'b1;
    repeat (10) cycle();
    #1;
    chk("bp_rsp_held", 32'(bus.rsp_valid), 32'd1);
    bus.host_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    repeat (4) cycle();
    #1;
    chk("bp_ready_back", 32'(bus.host_ready), 32'd1);
    chk("bp_drained",    32'(bus.rsp_valid),  32'd0);

    // Randomized traffic with legal responses.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bus.host_valid = 1'($urandom_range(0, 1));
      bus.host_wen   = 1'($urandom_range(0, 1));
      bus.host_addr  = 12'($urandom);
      bus.host_wdata = 16'($urandom);
      bus.mem_freeze = ($urandom_range(0, 3) == 0);
      bus.rsp_ready  = ($urandom_range(0, 3) != 0);
      cand.delete();
      foreach (q[i]) if (!q[i].done && !(issuing && i == q.size() - 1)) cand.push_back(int'(q[i].tag));
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_tag   = 2'(cand[$urandom_range(0, cand.size() - 1)]);
        bus.mem_rsp_data  = 16'($urandom);
      end else begin
        bus.mem_rsp_valid = 1'b0;
      end
      cycle();
    end
    bus.host_valid = 1'b0; bus.mem_freeze = 1'b0; bus.mem_rsp_valid = 1'b0; bus.rsp_ready = 1'b1;

    // Response for an unallocated tag while idle.
    do_reset();
    respond(3, 16'h1234);
    #1;
    chk("err_flag",      32'(bus.rsp_tag_err), 32'd1);
    chk("err_rsp_valid", 32'(bus.rsp_valid),   32'd0);
    repeat (3) cycle();

    // Reset with two outstanding, then a stale response.
    do_reset();
    req(1'b0);
    cycle();
    req(1'b1);
    cycle();
    bus.host_valid = 1'b0;
    cycle();
    do_reset();
    #1;
    chk("mrst_mem_valid",  32'(bus.mem_valid),  32'd0);
    chk("mrst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
    chk("mrst_host_ready", 32'(bus.host_ready), 32'd1);
    respond(0, 16'h5555);
    #1;
    chk("stale_err", 32'(bus.rsp_tag_err), 32'd1);
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_requester.md
MEM_PORT_REQUESTER -- requirements
Module: mem_port_requester

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, the maximum number of allocated tags (legal 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, with reset synchronous and active-high.
REQ-004 SHALL have port host_valid, input, 1, host request present.
REQ-005 SHALL have port host_ready, output, 1, requester accepts the host request this cycle.
REQ-006 SHALL have port host_addr, input, 12, request address.
REQ-007 SHALL have port host_wen, input, 1, 1=write, 0=read.
REQ-008 SHALL have port host_wdata, input, 16, write data.
REQ-009 SHALL have port mem_req_tag, output, 2, tag of the issued request.
REQ-010 SHALL have port mem_addr, output, 12, issued address.
REQ-011 SHALL have port mem_data, output, 16, issued write data.
REQ-012 SHALL have port mem_wen, output, 1, issued write enable.
REQ-013 SHALL have port mem_valid, output, 1, issued request valid.
REQ-014 SHALL have port mem_freeze, input, 1, memory not taking inputs this cycle.
REQ-015 SHALL have port mem_rsp_tag, input, 2, tag of the returning response.
REQ-016 SHALL have port mem_rsp_data, input, 16, response data.
REQ-017 SHALL have port mem_rsp_valid, input, 1, response valid.
REQ-018 SHALL have port rsp_valid, output, 1, in-order response to host available.
REQ-019 SHALL have port rsp_ready, input, 1, host takes the response.
REQ-020 SHALL have port rsp_data, output, 16, read data (0 for writes).
REQ-021 SHALL have port rsp_wen, output, 1, response belongs to a write.
REQ-022 SHALL have port rsp_tag_err, output, 1, sticky flag for a protocol-violating response.

Function
REQ-023 SHALL implement an issue FSM with states IDLE (mem_valid=0) and ISSUE (mem_valid=1).
REQ-024 SHALL assert host_ready = (outstanding < MAX_OUTSTANDING) & (IDLE | mem_fire), where mem_fire = mem_valid & ~mem_freeze; outstanding comes from registers only.
REQ-025 SHALL, on host accept, allocate tag alloc_ptr, register addr/wen/wdata (mem_data=0 for reads) and enter ISSUE, so mem_valid is high the next cycle.
REQ-026 SHALL hold all mem_* outputs stable while in ISSUE with mem_freeze=1, re-presenting the request every cycle until mem_fire.
REQ-027 SHALL, on mem_fire without a new accept, return to IDLE; on mem_fire with a new accept, stay in ISSUE with the new request (back-to-back, one request per cycle).
REQ-028 SHALL keep a 4-entry table indexed by tag holding busy, done, wen and data; on allocation, busy=1 and done=0; alloc_ptr increments mod 4.
REQ-029 SHALL, on mem_rsp_valid for a tag with busy=1 and done=0, capture mem_rsp_data and set done=1; the response is eligible for the host the next cycle.
REQ-030 SHALL, on mem_rsp_valid for a tag with busy=0 or done=1, leave the table unchanged and set rsp_tag_err=1 until reset.
REQ-031 SHALL drive rsp_valid = busy[head] & done[head], and drive rsp_data and rsp_wen from entry head; returns are strictly in allocation order.
REQ-032 SHALL, on rsp_valid & rsp_ready, clear the head entry and increment head mod 4; it SHALL NOT drop responses while rsp_ready=0.
REQ-033 SHALL update outstanding by +1 on accept and -1 on retire; a simultaneous accept and retire leaves it unchanged; it never exceeds MAX_OUTSTANDING.
REQ-034 SHALL handle a response arriving for one tag and a retire of another tag in the same cycle independently.
REQ-035 SHALL leave outputs that are not valid (mem_* while IDLE, rsp_* while rsp_valid=0) at 0.

Reset
REQ-036 SHALL, with reset=1 at a clock edge, clear state to IDLE, alloc_ptr=0, head=0, outstanding=0, all busy/done=0 and rsp_tag_err=0; outputs then read mem_valid=0, rsp_valid=0 and host_ready=1.
REQ-037 SHALL let reset override any in-flight request or pending response; responses arriving after reset for stale tags set rsp_tag_err.

Verification
REQ-038 SHALL cover a read at 0x123: accept cycle 0 -> mem_valid=1, mem_req_tag=0 at cycle 1; mem_rsp tag0 data 0xBEEF at cycle 3 -> rsp_valid=1, rsp_data=0xBEEF at cycle 4.
REQ-039 SHALL cover freeze: mem_freeze=1 for 3 cycles during ISSUE -> mem_* held constant; exactly one fire on the first cycle with freeze=0.
REQ-040 SHALL cover out-of-order returns: 4 reads (tags 0..3), responses in order 2,0,3,1 -> host sees tags 0,1,2,3 in order; host_ready=0 while outstanding=4.
REQ-041 SHALL cover backpressure: rsp_ready=0 for 10 cycles with all 4 entries done -> no loss; then 4 consecutive retires and host_ready returns to 1.
REQ-042 SHALL cover an error case: mem_rsp_valid with tag 3 while idle -> rsp_tag_err=1 sticky, rsp_valid stays 0.
REQ-043 SHALL cover reset mid-operation: reset with 2 outstanding -> next cycle outstanding=0, mem_valid=0, rsp_valid=0, host_ready=1.
